restador_serie: RTL

RESTADOR_SERIE -- requirements
Module: restador_serie

---
 rtl/restador_serie.sv | 114 +++++++++++
 1 files changed

// File: rtl/restador_serie.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, with a three-state handshake FSM.
// Optional build macro RESTADOR_SATURACION_EN clamps a borrowing result to zero.
module restador_serie #(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [ANCHO-1:0] X,
  input  logic [ANCHO-1:0] Y,
  output logic [ANCHO-1:0] R,
  output logic             AN,
  output logic             ocupado,
  output logic             listo
);

  localparam int CNT_W = (ANCHO > 1) ? $clog2(ANCHO) : 1;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(ANCHO - 1);

`ifdef RESTADOR_SATURACION_EN
  localparam logic SATURA = 1'b1;
`else
  localparam logic SATURA = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RESTA, FIN} estado_t;

  estado_t          estado;
  logic [ANCHO-1:0] x_sh;
  logic [ANCHO-1:0] y_sh;
  logic [ANCHO-2:0] d_sh;
  logic             b;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             b_sig;
  logic [ANCHO-1:0] res_sig;

  function automatic logic bit_dif(input logic xb, input logic yb, input logic bb);
    return xb ^ yb ^ bb;
  endfunction

  function automatic logic prestamo(input logic xb, input logic yb, input logic bb);
    return (~xb & yb) | (~(xb ^ yb) & bb);
  endfunction

  // A borrowing result is clamped to zero only in the saturating build.
  function automatic logic [ANCHO-1:0] saturar(input logic [ANCHO-1:0] dif, input logic prest);
    return (SATURA && prest) ? '0 : dif;
  endfunction

  always_comb begin
    d_bit   = bit_dif(x_sh[0], y_sh[0], b);
    b_sig   = prestamo(x_sh[0], y_sh[0], b);
    res_sig = {d_bit, d_sh};
  end

  // Control and datapath share one sequential process; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado  <= IDLE;
      x_sh    <= '0;
      y_sh    <= '0;
      d_sh    <= '0;
      b       <= 1'b0;
      cnt     <= '0;
      R       <= '0;
      AN      <= 1'b0;
      ocupado <= 1'b0;
      listo   <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          listo <= 1'b0;
          if (inicio) begin
            x_sh    <= X;
            y_sh    <= Y;
            d_sh    <= '0;
            b       <= 1'b0;
            cnt     <= '0;
            ocupado <= 1'b1;
            estado  <= RESTA;
          end
        end
        RESTA: begin
          x_sh <= x_sh >> 1;
          y_sh <= y_sh >> 1;
          b    <= b_sig;
          d_sh <= res_sig[ANCHO-1:1];
          // The counter stops at the last bit instead of wrapping.
          if (cnt == ULTIMO) begin
            R      <= saturar(res_sig, b_sig);
            AN     <= b_sig;
            listo  <= 1'b1;
            estado <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          listo   <= 1'b0;
          ocupado <= 1'b0;
          estado  <= IDLE;
        end
        default: begin
          listo   <= 1'b0;
          ocupado <= 1'b0;
          estado  <= IDLE;
        end
      endcase
    end
  end

endmodule
